// File: rtl/button_pulse_debouncer_if.sv
// rtl/button_pulse_debouncer_if.sv - pushbutton in, press strobe and debounced level out
interface button_pulse_debouncer_if;
  logic btn_in;     // raw, asynchronous, bouncing pushbutton (active-high)
  logic pulse;      // one-cycle strobe per accepted press
  logic btn_level;  // debounced button level

  // Bench / button side drives the raw input and observes the results.
  modport master (
    output btn_in,
    input  pulse,
    input  btn_level
  );

  // Debouncer side.
  modport slave (
    input  btn_in,
    output pulse,
    output btn_level
  );
endinterface

// File: rtl/button_pulse_debouncer.sv
// rtl/button_pulse_debouncer.sv - two-flop synchroniser plus press/release debounce FSM
module button_pulse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                     clk,
  input  logic                     rst,  // synchronous, active-low
  button_pulse_debouncer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Terminal count of a wait: the input has then been stable for
  // DEBOUNCE_CYCLES+1 consecutive samples including the one that started it.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             level_q;

  // Two-flop synchroniser; only sync2_q is allowed to reach the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM with registered pulse/level outputs; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      // The strobe is only ever raised for the single cycle after acceptance.
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= HELD;
            pulse_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.btn_level = level_q;

endmodule

// File: tb/tb_button_pulse_debouncer.sv
// tb/tb_button_pulse_debouncer.sv - randomized and directed checks of the pushbutton debouncer
`timescale 1ns/1ps
module tb_button_pulse_debouncer;

  localparam int D = 4;

  logic clk;
  logic rst;

  button_pulse_debouncer_if bus ();

  button_pulse_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run-length view of the synchronised input. The level
  // flips once the synchronised value has disagreed with it for D+1
  // consecutive samples; any agreeing sample restarts the run.
  int m_s1, m_s2, m_run, m_level, m_pulse;
  initial begin
    m_s1 = 0; m_s2 = 0; m_run = 0; m_level = 0; m_pulse = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_level = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_s2 != m_level) m_run = m_run + 1;
      else                 m_run = 0;
      if (m_run == D + 1) begin
        m_level = m_s2;
        m_pulse = m_s2;
        m_run   = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(bus.btn_in);
    end
  end

  // Every cycle: DUT outputs against the model; also feed a 2-bit counter stage.
  logic [1:0] stage_cnt = 2'd0;
  always @(negedge clk) begin
    chk("model_pulse", int'(bus.pulse), m_pulse);
    chk("model_level", int'(bus.btn_level), m_level);
    if (bus.pulse) stage_cnt = stage_cnt + 2'd1;
  end

  task automatic cyc(input logic b, input logic r);
    bus.btn_in = b;
    rst        = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds btn_in at b for n edges; reports the edge index (1-based) of the
  // first pulse, the pulse count, and the edge where the level fell.
  task automatic run(input logic b, input int n,
                     output int first_p, output int np, output int fall_e);
    logic prev;
    first_p = 0; np = 0; fall_e = 0;
    for (int i = 1; i <= n; i++) begin
      prev = bus.btn_level;
      cyc(b, 1'b1);
      if (bus.pulse) begin
        np++;
        if (first_p == 0) first_p = i;
      end
      if (prev && !bus.btn_level && fall_e == 0) fall_e = i;
    end
  endtask

  int fp, np, fe;
  logic [7:0] pat;

  initial begin
    bus.btn_in = 1'b0;
    rst        = 1'b0;

    // Reset with button held: outputs stay low, then one pulse at edge 7.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      chk("rst_held_pulse", int'(bus.pulse), 0);
      chk("rst_held_level", int'(bus.btn_level), 0);
    end
    run(1'b1, 10, fp, np, fe);
    chk("rst_release_first_pulse_edge", fp, 7);
    chk("rst_release_pulse_count", np, 1);
    chk("rst_release_level", int'(bus.btn_level), 1);

    // Release latency: level falls at edge D+3 of the 0.
    run(1'b0, 12, fp, np, fe);
    chk("release_fall_edge", fe, 7);
    chk("release_pulse_count", np, 0);

    // Clean press held 30 cycles: one pulse at edge 7, no auto-repeat.
    run(1'b1, 30, fp, np, fe);
    chk("clean_first_pulse_edge", fp, 7);
    chk("clean_pulse_count", np, 1);
    chk("clean_level", int'(bus.btn_level), 1);
    run(1'b0, 12, fp, np, fe);
    chk("clean_release_level", int'(bus.btn_level), 0);

    // Press bounce 1,1,0,1,0,1,1,0 then 0: rejected.
    pat = 8'b1101_0110;
    np  = 0;
    for (int i = 7; i >= 0; i--) begin
      cyc(pat[i], 1'b1);
      if (bus.pulse) np++;
    end
    chk("press_bounce_pulses", np, 0);
    run(1'b0, 12, fp, np, fe);
    chk("press_bounce_tail_pulses", np, 0);
    chk("press_bounce_level", int'(bus.btn_level), 0);

    // Release bounce: 0 x3, 1 x10 keeps level high; final 0 falls at edge 7.
    run(1'b1, 12, fp, np, fe);
    chk("rb_press_pulses", np, 1);
    run(1'b0, 3, fp, np, fe);
    chk("rb_glitch_level", int'(bus.btn_level), 1);
    run(1'b1, 10, fp, np, fe);
    chk("rb_no_second_pulse", np, 0);
    chk("rb_level_after_glitch", int'(bus.btn_level), 1);
    run(1'b0, 12, fp, np, fe);
    chk("rb_final_fall_edge", fe, 7);

    // Reset asserted mid press-debounce: no pulse ever.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("mid_rst_pulse", int'(bus.pulse), 0);
    chk("mid_rst_level", int'(bus.btn_level), 0);
    run(1'b0, 15, fp, np, fe);
    chk("mid_rst_after_pulses", np, 0);
    chk("mid_rst_after_level", int'(bus.btn_level), 0);

    // Counter stage integration: three clean presses advance 0->1->2->3.
    stage_cnt = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      run(1'b1, 10, fp, np, fe);
      run(1'b0, 12, fp, np, fe);
      chk("counter_stage_value", int'(stage_cnt), k);
    end

    // Randomized bursts with occasional resets, checked every cycle by the model.
    for (int c = 0; c < 3000; ) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        cyc(b, ($urandom_range(0, 299) != 0));
        c++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_pulse_debouncer.md
# button_pulse_debouncer

Upstream input stage for the two-bit counter stage: takes a raw, asynchronous, bouncing pushbutton, synchronises and debounces it, and emits a single-cycle `pulse` per accepted press. `pulse` is the count-advance strobe for the downstream counter. A debounced level output is also provided for status LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles the synchronised input must hold a new level before it is accepted. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of the internal stability counter. Derived; do not override.

- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-low: `rst`=0 at a rising edge resets the block.
- `btn_in`  input  1  raw pushbutton, asynchronous to `clk`, may bounce. Active-high.
- `pulse`  output  1  registered, high for exactly one cycle per accepted press.
- `btn_level`  output  1  registered debounced button level.

## Operation
- **Synchroniser:** two flops, `sync1` ← `btn_in`, `sync2` ← `sync1`. Only `sync2` feeds the FSM.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Stability counter `cnt` is `CNT_W` bits.
- **IDLE:**
  - `sync2`=1 → PRESS_WAIT, `cnt`←0.
  - Otherwise stay.
- **PRESS_WAIT:**
  - `sync2`=0 → IDLE (bounce rejected, no pulse).
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1 → HELD, `pulse`←1, `btn_level`←1.
  - Else `cnt`←`cnt`+1.
- **HELD:**
  - `sync2`=0 → RELEASE_WAIT, `cnt`←0.
  - Otherwise stay.
- **RELEASE_WAIT:**
  - `sync2`=1 → HELD (release bounce rejected, no new pulse).
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE, `btn_level`←0.
  - Else `cnt`←`cnt`+1.
- `pulse` is 0 in every cycle except the one following the PRESS_WAIT→HELD transition. It never stays high for two consecutive cycles.
- Holding the button indefinitely produces exactly one pulse. There is no auto-repeat.
- `cnt` never exceeds `DEBOUNCE_CYCLES`-1, so there is no wrap-around. `cnt` is cleared on every state entry that starts a wait.
- **Reset:**
  - `sync1`, `sync2`, `cnt`, `pulse` and `btn_level` are all 0; state is IDLE.
  - Reset overrides every transition, including mid-wait and the cycle in which `pulse` would assert.
  - A button already held when `rst` deasserts is treated as a new press: it is debounced and produces one pulse.

## Timing
- **Press latency:** number edges so that edge 1 is the first rising edge sampling `btn_in`=1, with `btn_in` held stable after that.
  - `sync2`=1 after edge 2.
  - PRESS_WAIT with `cnt`=0 after edge 3.
  - `cnt`=`DEBOUNCE_CYCLES`-1 after edge `DEBOUNCE_CYCLES`+2.
  - `pulse` and `btn_level` go high after edge `DEBOUNCE_CYCLES`+3; `pulse` drops after the next edge.
  - With the default of 4: `pulse` is high in the cycle after edge 7.
- **Release latency:** `btn_level` falls after edge `DEBOUNCE_CYCLES`+3, counted from the first edge sampling `btn_in`=0.
- **Minimum press-to-press spacing** for two pulses: a full release debounce plus a full press debounce.
- **Bounce rejection:** a high or low excursion of `sync2` lasting fewer than `DEBOUNCE_CYCLES`+1 cycles is ignored.
- Outputs are pure registers, with no combinational path from `btn_in` or `rst` to `pulse` or `btn_level`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and a 10 ns clock.
- **Reset with button held:** hold `rst`=0 for 3 edges with `btn_in`=1 → `pulse`=0 and `btn_level`=0 throughout. Release `rst` → one pulse after the 7th edge following release, and `btn_level`=1 from the same edge.
- **Clean press:** `btn_in` 0→1, held for 30 cycles → exactly one `pulse` cycle, after edge 7. `btn_level` stays 1 until release; `pulse` count is 1.
- **Press bounce:** `btn_in` pattern 1,1,0,1,0,1,1,0 (one value per cycle), then held at 0 → no pulse, `btn_level` stays 0, FSM returns to IDLE.
- **Release bounce:** in HELD, drive `btn_in` to 0 for 3 cycles, then 1 for 10 cycles, then 0 → `btn_level` stays 1 through the glitch with no second pulse. `btn_level` falls after edge 7 of the final 0.
- **Reset mid-debounce:** assert `rst`=0 at the edge where `cnt`=2 in PRESS_WAIT → `pulse` never asserts, state is IDLE and `cnt`=0 after that edge.
- **Counter stage integration:** three separated clean presses into the two-bit counter stage → counter goes 0→1→2→3, one increment per press.
